dff_share_arbiter: RTL and testbench
====================================

DFF_SHARE_ARBITER -- requirements
Module: dff_share_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the flip-flop; range 2-8.
REQ-002 Parameter HOLD_MAX, default 8: maximum ownership cycles when the timeout feature is compiled in; range 2-255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  NREQ  per-requester level request; bit i held high while requester i wants ownership.
REQ-006 din  input  NREQ  per-requester data bit; bit i is the d input offered by requester i.
REQ-007 gnt  output  NREQ  registered grant; one-hot or all-zero.
REQ-008 owner  output  clog2(NREQ)  registered index of current or last owner.
REQ-009 busy  output  1  high while in state OWN.
REQ-010 q  output  1  shared flip-flop output.
REQ-011 qn  output  1  complement of q.

Function
REQ-012 FSM states SHALL be IDLE and OWN; busy = (state == OWN).
REQ-013 Round-robin pointer ptr SHALL select the winner as the first set req bit searched from ptr upward, wrapping at NREQ-1 to 0.
REQ-014 IDLE, req != 0 at edge: next state OWN; gnt = one-hot(winner); owner = winner; q <= din[winner] at that same edge; hold_cnt <= 0.
REQ-015 IDLE, req == 0: stay IDLE; gnt = 0; q holds.
REQ-016 OWN, req[owner] high, no forced handoff: q <= din[owner] every edge; gnt unchanged; hold_cnt increments, saturating at HOLD_MAX-1.
REQ-017 OWN, req[owner] low at edge: ptr <= owner+1 (wrapping); if another req bit set, grant the next winner at the same edge, with no idle cycle, and apply REQ-014 load; otherwise go IDLE, gnt = 0, q holds last value.
REQ-018 A requester's owner drop and another requester's rise on the same edge SHALL hand off at that edge.
REQ-019 din bits of non-owners SHALL never affect q.
REQ-020 qn SHALL equal ~q at all times, including during reset.
REQ-021 gnt, owner, busy, and q SHALL change only on clk rising edge or on rst_n assertion.
REQ-022 Requests arriving in the same cycle as a grant SHALL wait; no more than one grant change per edge.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, gnt = 0, owner = 0, ptr = 0, hold_cnt = 0, busy = 0, q = 0, qn = 1.
REQ-024 Reset asserted mid-ownership SHALL abort ownership with no handoff; after release, arbitration restarts from ptr = 0.
REQ-025 Deassertion of rst_n SHALL take effect at the first rising edge of clk where rst_n is high.

Configuration
REQ-026 Macro DFF_SHARE_ARB_TIMEOUT_EN defined: in OWN, when hold_cnt == HOLD_MAX-1 and any other req bit is set, the next edge SHALL force a handoff per REQ-017 (ptr <= owner+1), so an owner holds at most HOLD_MAX cycles while others wait.
REQ-027 Macro DFF_SHARE_ARB_TIMEOUT_EN undefined: no forced handoff; the owner keeps the flip-flop until it drops req; HOLD_MAX is unused.

Verification
REQ-028 Stimulus: rst_n = 0 during OWN with q = 1. Response: q = 0, qn = 1, gnt = 0, busy = 0 immediately, before the next clk edge.
REQ-029 Stimulus: from IDLE, req = 0100 and din[2] = 1. Response: after one edge, gnt = 0100, owner = 2, busy = 1, q = 1; when din[2] toggles 0,1,0 on successive cycles, q follows one edge later each time.
REQ-030 Stimulus: after reset, req = 1111; each owner drops its req one cycle after being granted, then re-raises it. Response: grant order is 0,1,2,3,0 with no gnt = 0 cycle between grants.
REQ-031 Stimulus: owner 0 holds; din[1] toggles while req[1] = 1. Response: q tracks only din[0]; gnt stays 0001.
REQ-032 Stimulus: HOLD_MAX = 8; req[0] held; req[3] rises at the 2nd cycle of ownership. Response with macro defined: gnt = 1000 after exactly 8 ownership cycles. Response with macro undefined: gnt stays 0001 indefinitely.
REQ-033 Stimulus: sole owner 1 drops req with q = 1. Response: next edge state IDLE, gnt = 0, busy = 0, q = 1 held, owner = 1.

Source files
------------

// File: rtl/dff_share_arbiter_if.sv
// dff_share_arbiter_if: request/data/grant bundle between requesters and the
// shared flip-flop arbiter. The master side drives req/din; the slave side
// (the arbiter) drives grant, owner, busy and the shared q/qn.
interface dff_share_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] din;
  logic [NREQ-1:0] gnt;
  logic [OW-1:0]   owner;
  logic            busy;
  logic            q;
  logic            qn;

  modport master (
    output req,
    output din,
    input  gnt,
    input  owner,
    input  busy,
    input  q,
    input  qn
  );

  modport slave (
    input  req,
    input  din,
    output gnt,
    output owner,
    output busy,
    output q,
    output qn
  );
endinterface

// File: rtl/dff_share_arbiter.sv
// dff_share_arbiter: one flip-flop time-shared between NREQ requesters.
// A round-robin arbiter grants ownership; the owner's din bit is loaded into
// q every cycle it holds the grant. Hand-offs happen at the same edge the
// owner drops its request, with no idle cycle in between.
// Optional feature macro: DFF_SHARE_ARB_TIMEOUT_EN -- when defined, an owner
// that has held for HOLD_MAX cycles is forced to hand off if anyone else waits.
module dff_share_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dff_share_arbiter_if.slave    bus
);

  localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned HW = 8;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t          r_state;
  logic [OW-1:0]   r_ptr;
  logic [OW-1:0]   r_owner;
  logic [NREQ-1:0] r_gnt;
  logic            r_q;
  logic [HW-1:0]   r_hold_cnt;

  logic [OW-1:0]   w_owner_next;
  logic [OW-1:0]   w_base;
  logic [OW-1:0]   w_win;
  logic            w_found;
  logic            w_force;

  // Index following the current owner, wrapping at NREQ-1.
  assign w_owner_next = (r_owner == OW'(NREQ - 1)) ? '0 : (r_owner + OW'(1));

  // In OWN the search starts past the owner, which is where ptr is about to
  // move on any hand-off; in IDLE it starts at the stored pointer.
  assign w_base = (r_state == OWN) ? w_owner_next : r_ptr;

  // Forced hand-off once the owner has saturated its hold budget and someone waits.
`ifdef DFF_SHARE_ARB_TIMEOUT_EN
  assign w_force = (r_hold_cnt == HW'(HOLD_MAX - 1)) && (|(bus.req & ~r_gnt));
`else
  assign w_force = 1'b0;
`endif

  // Round-robin search: first set req bit from w_base upward, wrapping.
  always_comb begin
    int unsigned v_idx;
    w_win   = '0;
    w_found = 1'b0;
    v_idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      v_idx = 32'(w_base) + i;
      if (v_idx >= NREQ) v_idx = v_idx - NREQ;
      if (!w_found && bus.req[OW'(v_idx)]) begin
        w_found = 1'b1;
        w_win   = OW'(v_idx);
      end
    end
  end

  // Arbitration FSM and the shared flip-flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_gnt      <= '0;
      r_q        <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state    <= OWN;
            r_gnt      <= NREQ'(1) << w_win;
            r_owner    <= w_win;
            r_q        <= bus.din[w_win];
            r_hold_cnt <= '0;
          end
        end
        OWN: begin
          if (!bus.req[r_owner] || w_force) begin
            r_ptr <= w_owner_next;
            if (w_found) begin
              r_gnt      <= NREQ'(1) << w_win;
              r_owner    <= w_win;
              r_q        <= bus.din[w_win];
              r_hold_cnt <= '0;
            end else begin
              r_state <= IDLE;
              r_gnt   <= '0;
            end
          end else begin
            r_q <= bus.din[r_owner];
            if (r_hold_cnt < HW'(HOLD_MAX - 1)) r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.owner = r_owner;
  assign bus.busy  = (r_state == OWN);
  assign bus.q     = r_q;
  assign bus.qn    = ~r_q;

endmodule

// File: tb/tb_dff_share_arbiter.sv
// tb_dff_share_arbiter: directed checks of grant, hand-off, data isolation,
// reset and (when compiled in) the hold timeout of dff_share_arbiter.
`timescale 1ns/1ps
module tb_dff_share_arbiter;

  localparam int unsigned NREQ = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  dff_share_arbiter_if #(.NREQ(NREQ)) bus ();

  dff_share_arbiter #(.NREQ(NREQ), .HOLD_MAX(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req = '0;
    bus.din = '0;
    rst_n   = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    bus.req = '0;
    bus.din = '0;
    rst_n   = 1'b0;
    #3;
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt got %b want 0000", bus.gnt); end
    n_cmp++; if (bus.owner !== 2'd0) begin n_err++; $display("FAIL reset_owner got %0d want 0", bus.owner); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.q !== 1'b0) begin n_err++; $display("FAIL reset_q got %b want 0", bus.q); end
    n_cmp++; if (bus.qn !== 1'b1) begin n_err++; $display("FAIL reset_qn got %b want 1", bus.qn); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL idle_after_reset busy got %b want 0", bus.busy); end
  endtask

  task automatic test_grant_follow();
    logic exp_q [3];
    exp_q[0] = 1'b0; exp_q[1] = 1'b1; exp_q[2] = 1'b0;
    do_reset();
    bus.req = 4'b0100;
    bus.din = 4'b0100;
    step();
    n_cmp++; if (bus.gnt !== 4'b0100) begin n_err++; $display("FAIL grant_gnt got %b want 0100", bus.gnt); end
    n_cmp++; if (bus.owner !== 2'd2) begin n_err++; $display("FAIL grant_owner got %0d want 2", bus.owner); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL grant_busy got %b want 1", bus.busy); end
    n_cmp++; if (bus.q !== 1'b1) begin n_err++; $display("FAIL grant_q got %b want 1", bus.q); end
    for (int k = 0; k < 3; k++) begin
      bus.din[2] = exp_q[k];
      n_cmp++; if (bus.q === exp_q[k] && k != 1) begin n_err++; $display("FAIL follow_early%0d q changed before edge got %b", k, bus.q); end
      step();
      n_cmp++; if (bus.q !== exp_q[k]) begin n_err++; $display("FAIL follow%0d q got %b want %b", k, bus.q, exp_q[k]); end
      n_cmp++; if (bus.qn !== ~exp_q[k]) begin n_err++; $display("FAIL follow%0d qn got %b want %b", k, bus.qn, ~exp_q[k]); end
    end
  endtask

  task automatic test_isolation();
    logic [3:0] vec_din [4];
    logic       vec_q   [4];
    vec_din[0] = 4'b0010; vec_q[0] = 1'b0;
    vec_din[1] = 4'b0001; vec_q[1] = 1'b1;
    vec_din[2] = 4'b1110; vec_q[2] = 1'b0;
    vec_din[3] = 4'b1101; vec_q[3] = 1'b1;
    do_reset();
    bus.req = 4'b0001;
    bus.din = 4'b0001;
    step();
    bus.req = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      bus.din = vec_din[k];
      step();
      n_cmp++; if (bus.q !== vec_q[k]) begin n_err++; $display("FAIL isolate%0d q got %b want %b", k, bus.q, vec_q[k]); end
      n_cmp++; if (bus.gnt !== 4'b0001) begin n_err++; $display("FAIL isolate%0d gnt got %b want 0001", k, bus.gnt); end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt [5];
    exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100;
    exp_gnt[3] = 4'b1000; exp_gnt[4] = 4'b0001;
    do_reset();
    bus.req = 4'b1111;
    step();
    n_cmp++; if (bus.gnt !== exp_gnt[0]) begin n_err++; $display("FAIL rr0 gnt got %b want %b", bus.gnt, exp_gnt[0]); end
    for (int k = 1; k < 5; k++) begin
      bus.req = 4'b1111 & ~exp_gnt[k-1];
      step();
      n_cmp++; if (bus.gnt !== exp_gnt[k]) begin n_err++; $display("FAIL rr%0d gnt got %b want %b", k, bus.gnt, exp_gnt[k]); end
      n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rr%0d busy got %b want 1", k, bus.busy); end
    end
  endtask

  task automatic test_release();
    do_reset();
    bus.req = 4'b0010;
    bus.din = 4'b0010;
    step();
    n_cmp++; if (bus.q !== 1'b1) begin n_err++; $display("FAIL release_pre q got %b want 1", bus.q); end
    bus.req = 4'b0000;
    bus.din = 4'b0000;
    step();
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL release busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL release gnt got %b want 0000", bus.gnt); end
    n_cmp++; if (bus.q !== 1'b1) begin n_err++; $display("FAIL release q got %b want 1", bus.q); end
    n_cmp++; if (bus.owner !== 2'd1) begin n_err++; $display("FAIL release owner got %0d want 1", bus.owner); end
    step();
    n_cmp++; if (bus.q !== 1'b1) begin n_err++; $display("FAIL idle_hold q got %b want 1", bus.q); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req = 4'b0001;
    bus.din = 4'b0101;
    step();
    bus.req = 4'b0100;
    step();
    n_cmp++; if (bus.gnt !== 4'b0100) begin n_err++; $display("FAIL mid_pre gnt got %b want 0100", bus.gnt); end
    n_cmp++; if (bus.q !== 1'b1) begin n_err++; $display("FAIL mid_pre q got %b want 1", bus.q); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.q !== 1'b0) begin n_err++; $display("FAIL mid_rst q got %b want 0", bus.q); end
    n_cmp++; if (bus.qn !== 1'b1) begin n_err++; $display("FAIL mid_rst qn got %b want 1", bus.qn); end
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL mid_rst gnt got %b want 0000", bus.gnt); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_rst busy got %b want 0", bus.busy); end
    bus.req = 4'b1001;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++; if (bus.gnt !== 4'b0001) begin n_err++; $display("FAIL ptr_restart gnt got %b want 0001", bus.gnt); end
  endtask

  task automatic test_timeout();
    logic [3:0] exp_final;
`ifdef DFF_SHARE_ARB_TIMEOUT_EN
    exp_final = 4'b1000;
`else
    exp_final = 4'b0001;
`endif
    do_reset();
    bus.req = 4'b0001;
    step();
    bus.req = 4'b1001;
    for (int k = 1; k < 8; k++) begin
      step();
      n_cmp++; if (bus.gnt !== 4'b0001) begin n_err++; $display("FAIL hold%0d gnt got %b want 0001", k, bus.gnt); end
    end
    step();
    n_cmp++; if (bus.gnt !== exp_final) begin n_err++; $display("FAIL timeout gnt got %b want %b", bus.gnt, exp_final); end
    for (int k = 0; k < 4; k++) step();
    n_cmp++; if (bus.gnt !== exp_final) begin n_err++; $display("FAIL timeout_late gnt got %b want %b", bus.gnt, exp_final); end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    bus.req = '0;
    bus.din = '0;
    test_reset();
    test_grant_follow();
    test_isolation();
    test_round_robin();
    test_release();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
